// File: rtl/bypass_amo_responder_pkg.sv
// bypass_amo_responder_pkg: bypass request/response types, AMO encodings, responder state and backend beat.
package bypass_amo_responder_pkg;

  typedef enum logic [3:0] {
    AMO_NONE = 4'b0000,
    AMO_LR   = 4'b0001,
    AMO_SC   = 4'b0010,
    AMO_SWAP = 4'b0011,
    AMO_ADD  = 4'b0100,
    AMO_AND  = 4'b0101,
    AMO_OR   = 4'b0110,
    AMO_XOR  = 4'b0111,
    AMO_MAX  = 4'b1000,
    AMO_MAXU = 4'b1001,
    AMO_MIN  = 4'b1010,
    AMO_MINU = 4'b1011,
    AMO_CAS1 = 4'b1100,
    AMO_CAS2 = 4'b1101
  } amo_t;

  typedef struct packed {
    logic        req;
    logic        we;
    amo_t        amo;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } bypass_req_t;

  typedef struct packed {
    logic        gnt;
    logic        valid;
    logic [63:0] rdata;
  } bypass_rsp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_W,
    ST_WR,
    ST_WR_W,
    ST_SC_CHK,
    ST_RESP
  } bypass_rsp_state_e;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } bypass_mem_req_t;

  // Word AMOs touch only the lane picked by addr[2]; double-word AMOs touch all bytes.
  function automatic logic [7:0] amo_be(input logic [1:0] size, input logic lane);
    return (size == 2'b10) ? (lane ? 8'hF0 : 8'h0F) : 8'hFF;
  endfunction

endpackage

// File: rtl/bypass_amo_responder_amo_alu.sv
// amo_alu: combinational read-modify-write datapath for 32/64-bit atomics.
module amo_alu
  import bypass_amo_responder_pkg::*;
(
  input  amo_t        amo_i,
  input  logic [1:0]  size_i,
  input  logic        lane_i,
  input  logic [63:0] old_i,
  input  logic [63:0] operand_i,
  output logic [63:0] wdata_o,
  output logic        we_o
);
  logic        w32, sgn, lt;
  logic [31:0] old_l;
  logic [63:0] a, b, r;
  // Word operands are widened by signedness so one 64-bit compare serves both sizes; operand sits in the low word.
  always_comb begin
    w32   = size_i == 2'b10;
    sgn   = amo_i == AMO_MAX || amo_i == AMO_MIN;
    old_l = lane_i ? old_i[63:32] : old_i[31:0];
    a     = w32 ? {{32{sgn && old_l[31]}}, old_l} : old_i;
    b     = w32 ? {{32{sgn && operand_i[31]}}, operand_i[31:0]} : operand_i;
    lt    = sgn ? ($signed(a) < $signed(b)) : (a < b);
    case (amo_i)
      AMO_SWAP:           r = b;
      AMO_ADD:            r = a + b;
      AMO_AND:            r = a & b;
      AMO_OR:             r = a | b;
      AMO_XOR:            r = a ^ b;
      AMO_MAX, AMO_MAXU:  r = lt ? b : a;
      AMO_MIN, AMO_MINU:  r = lt ? a : b;
      default:            r = a;
    endcase
    wdata_o = w32 ? {2{r[31:0]}} : r;
    we_o    = !(amo_i inside {AMO_NONE, AMO_LR, AMO_SC, AMO_CAS1, AMO_CAS2});
  end
endmodule

// File: rtl/bypass_amo_responder.sv
// bypass_amo_responder: serves one bypass request at a time on a single-beat backend, with RMW atomics and LR/SC.
module bypass_amo_responder
  import bypass_amo_responder_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  bypass_req_t bypass_req_i,
  output bypass_rsp_t bypass_rsp_o,
  output logic        mem_req_o,
  input  logic        mem_gnt_i,
  output logic        mem_we_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic [7:0]  mem_be_o,
  input  logic        mem_rvalid_i,
  input  logic [63:0] mem_rdata_i
);
  bypass_rsp_state_e state_q, state_d;
  bypass_req_t       req_q, req_d;
  bypass_mem_req_t   mem_q, mem_d;
  logic [63:0]       result_q, result_d;
  logic              resv_valid_q, resv_valid_d;
  logic [60:0]       resv_addr_q, resv_addr_d;
  logic [63:0]       alu_wdata, old_ext;
  logic [31:0]       old_lane;
  logic              alu_we, rd_fin, wr_fin, resv_hit, unused;

  amo_alu u_amo_alu (
    .amo_i     (req_q.amo),
    .size_i    (req_q.size),
    .lane_i    (req_q.addr[2]),
    .old_i     (mem_rdata_i),
    .operand_i (req_q.wdata),
    .wdata_o   (alu_wdata),
    .we_o      (alu_we)
  );

  assign old_lane = req_q.addr[2] ? mem_rdata_i[63:32] : mem_rdata_i[31:0];
  assign old_ext  = (req_q.size == 2'b10) ? {{32{old_lane[31]}}, old_lane} : mem_rdata_i;
  assign resv_hit = resv_valid_q && resv_addr_q == req_q.addr[63:3];
  // A response arriving together with the grant completes the access without visiting the wait state.
  assign rd_fin   = mem_rvalid_i && (state_q == ST_RD_W || (state_q == ST_RD && mem_gnt_i));
  assign wr_fin   = mem_rvalid_i && (state_q == ST_WR_W || (state_q == ST_WR && mem_gnt_i));
  assign unused   = ^{req_q.req, req_q.we, req_q.addr[1:0]};

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    mem_d        = mem_q;
    result_d     = result_q;
    resv_valid_d = resv_valid_q;
    resv_addr_d  = resv_addr_q;
    case (state_q)
      ST_IDLE: if (bypass_req_i.req) begin
        req_d    = bypass_req_i;
        result_d = '0;
        state_d  = (bypass_req_i.amo == AMO_SC) ? ST_SC_CHK :
                   (bypass_req_i.we && bypass_req_i.amo == AMO_NONE) ? ST_WR : ST_RD;
        mem_d    = (state_d == ST_SC_CHK) ? '0 : bypass_mem_req_t'{
          req:   1'b1,
          we:    state_d == ST_WR,
          addr:  {bypass_req_i.addr[63:3], 3'b000},
          wdata: (state_d == ST_WR) ? bypass_req_i.wdata : '0,
          be:    (state_d == ST_WR) ? bypass_req_i.be : 8'hFF
        };
      end
      ST_RD: if (mem_gnt_i) begin
        mem_d   = '0;
        state_d = ST_RD_W;
      end
      ST_WR: if (mem_gnt_i) begin
        mem_d        = '0;
        state_d      = ST_WR_W;
        resv_valid_d = resv_valid_q && !resv_hit;
      end
      ST_SC_CHK: begin
        resv_valid_d = 1'b0;
        result_d     = {63'd0, !resv_hit};
        state_d      = resv_hit ? ST_WR : ST_RESP;
        mem_d        = resv_hit ? bypass_mem_req_t'{1'b1, 1'b1, {req_q.addr[63:3], 3'b000}, req_q.wdata, req_q.be} : '0;
      end
      ST_RESP: state_d = ST_IDLE;
      default: ;
    endcase
    if (rd_fin) begin
      result_d = (req_q.amo == AMO_NONE || req_q.amo == AMO_LR) ? mem_rdata_i : old_ext;
      state_d  = alu_we ? ST_WR : ST_RESP;
      mem_d    = alu_we ? bypass_mem_req_t'{1'b1, 1'b1, {req_q.addr[63:3], 3'b000}, alu_wdata,
                                            amo_be(req_q.size, req_q.addr[2])} : '0;
      if (req_q.amo == AMO_LR) begin
        resv_valid_d = 1'b1;
        resv_addr_d  = req_q.addr[63:3];
      end
    end
    if (wr_fin) state_d = ST_RESP;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      mem_q        <= '0;
      result_q     <= '0;
      resv_valid_q <= 1'b0;
      resv_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      mem_q        <= mem_d;
      result_q     <= result_d;
      resv_valid_q <= resv_valid_d;
      resv_addr_q  <= resv_addr_d;
    end
  end

  assign bypass_rsp_o = '{
    gnt:   rst_ni && state_q == ST_IDLE && bypass_req_i.req,
    valid: state_q == ST_RESP,
    rdata: (state_q == ST_RESP) ? result_q : '0
  };
  assign mem_req_o   = mem_q.req;
  assign mem_we_o    = mem_q.we;
  assign mem_addr_o  = mem_q.addr;
  assign mem_wdata_o = mem_q.wdata;
  assign mem_be_o    = mem_q.be;
endmodule
